// File: rtl/spm_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto one synchronous-read SPM bus.
// Latency: grant is combinational; read data/valid returns exactly one cycle after grant.
// Backpressure: the loser of a cycle sees *_busy high; MEM wins unless IF has waited MEM_BURST_MAX grants.
module spm_arbiter #(
    parameter int unsigned MEM_BURST_MAX = 4  // legal range 1..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] if_spm_addr,
    input  logic        if_spm_as_,
    input  logic        if_flush,
    output logic [31:0] if_spm_rd_data,
    output logic        if_rd_valid,
    output logic        if_busy,
    input  logic [29:0] mem_spm_addr,
    input  logic        mem_spm_as_,
    input  logic        mem_spm_rw,
    input  logic [31:0] mem_spm_wr_data,
    output logic [31:0] mem_spm_rd_data,
    output logic        mem_rd_valid,
    output logic        mem_busy,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] spm_rd_data
);

    localparam logic        ENABLE_   = 1'b0;
    localparam logic        DISABLE_  = 1'b1;
    localparam logic        READ      = 1'b1;
    localparam logic [31:0] ISA_NOP   = 32'h0000_0000;
    localparam logic [2:0]  BURST_MAX = 3'(MEM_BURST_MAX);

    typedef enum logic [1:0] {OWN_IDLE, OWN_IF, OWN_MEM} owner_t;

    owner_t     rd_owner, rd_owner_nxt;
    logic [2:0] starve_cnt, starve_cnt_nxt;
    logic       if_req, mem_req, if_prio, grant_if, grant_mem;

    assign if_req    = (if_spm_as_ == ENABLE_);
    assign mem_req   = (mem_spm_as_ == ENABLE_);
    // IF only jumps the queue once it has lost BURST_MAX consecutive contended cycles.
    assign if_prio   = if_req && mem_req && (starve_cnt == BURST_MAX);
    assign grant_mem = mem_req && !if_prio;
    assign grant_if  = if_req && !grant_mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner   <= OWN_IDLE;
            starve_cnt <= 3'd0;
        end else begin
            rd_owner   <= rd_owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        rd_owner_nxt    = OWN_IDLE;
        starve_cnt_nxt  = 3'd0;
        spm_as_         = DISABLE_;
        spm_addr        = '0;
        spm_rw          = READ;
        spm_wr_data     = '0;
        if_busy         = if_req && !grant_if;
        mem_busy        = mem_req && !grant_mem;
        if_rd_valid     = (rd_owner == OWN_IF) && !if_flush;
        mem_rd_valid    = (rd_owner == OWN_MEM);
        if_spm_rd_data  = ISA_NOP;
        mem_spm_rd_data = '0;

        if (grant_mem) begin
            spm_as_     = ENABLE_;
            spm_addr    = mem_spm_addr;
            spm_rw      = mem_spm_rw;
            spm_wr_data = mem_spm_wr_data;
            if (mem_spm_rw == READ) begin
                rd_owner_nxt = OWN_MEM;
            end
        end else if (grant_if) begin
            spm_as_      = ENABLE_;
            spm_addr     = if_spm_addr;
            rd_owner_nxt = OWN_IF;
        end

        if (grant_mem && if_req) begin
            starve_cnt_nxt = (starve_cnt == BURST_MAX) ? starve_cnt : starve_cnt + 3'd1;
        end

        if (if_rd_valid) begin
            if_spm_rd_data = spm_rd_data;
        end
        if (mem_rd_valid) begin
            mem_spm_rd_data = spm_rd_data;
        end
    end

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed bench for spm_arbiter: stimulus pushes expected bus grants and read returns; a negedge monitor pops and compares.
module tb_spm_arbiter;

    localparam logic        READ    = 1'b1;
    localparam logic        WRITE   = 1'b0;
    localparam logic [31:0] ISA_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [29:0] addr;
        logic        rw;
        logic [31:0] wd;
        logic        ib;
        logic        mb;
    } bus_exp_t;

    typedef struct packed {
        logic        is_if;
        logic [31:0] d;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] if_spm_addr = '0;
    logic        if_spm_as_ = 1'b1;
    logic        if_flush = 1'b0;
    logic [31:0] if_spm_rd_data;
    logic        if_rd_valid;
    logic        if_busy;
    logic [29:0] mem_spm_addr = '0;
    logic        mem_spm_as_ = 1'b1;
    logic        mem_spm_rw = 1'b1;
    logic [31:0] mem_spm_wr_data = '0;
    logic [31:0] mem_spm_rd_data;
    logic        mem_rd_valid;
    logic        mem_busy;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data = '0;

    int checks = 0;
    int errors = 0;
    bus_exp_t bus_q[$];
    rd_exp_t  rd_q[$];

    spm_arbiter #(.MEM_BURST_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_spm_addr(if_spm_addr), .if_spm_as_(if_spm_as_), .if_flush(if_flush),
        .if_spm_rd_data(if_spm_rd_data), .if_rd_valid(if_rd_valid), .if_busy(if_busy),
        .mem_spm_addr(mem_spm_addr), .mem_spm_as_(mem_spm_as_), .mem_spm_rw(mem_spm_rw),
        .mem_spm_wr_data(mem_spm_wr_data), .mem_spm_rd_data(mem_spm_rd_data),
        .mem_rd_valid(mem_rd_valid), .mem_busy(mem_busy),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ia, input logic [29:0] iaddr, input logic fl,
                         input logic ma, input logic [29:0] maddr, input logic rw,
                         input logic [31:0] wd, input logic [31:0] rd);
        @(posedge clk);
        #1;
        if_spm_as_      = ia;
        if_spm_addr     = iaddr;
        if_flush        = fl;
        mem_spm_as_     = ma;
        mem_spm_addr    = maddr;
        mem_spm_rw      = rw;
        mem_spm_wr_data = wd;
        spm_rd_data     = rd;
    endtask

    task automatic idle(input logic [31:0] rd);
        drive(1'b1, 30'h0, 1'b0, 1'b1, 30'h0, READ, 32'h0, rd);
    endtask

    task automatic exp_bus(input logic [29:0] a, input logic rw, input logic [31:0] wd,
                           input logic ib, input logic mb);
        bus_exp_t e;
        e.addr = a; e.rw = rw; e.wd = wd; e.ib = ib; e.mb = mb;
        bus_q.push_back(e);
    endtask

    task automatic exp_rd(input logic is_if, input logic [31:0] d);
        rd_exp_t e;
        e.is_if = is_if; e.d = d;
        rd_q.push_back(e);
    endtask

    // Monitor: every granted bus cycle and every read return must match the head of its queue.
    always @(negedge clk) begin
        bus_exp_t b;
        rd_exp_t  r;
        if (spm_as_ == 1'b0) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_grant", {2'b0, spm_addr}, 32'hFFFF_FFFF);
            end else begin
                b = bus_q.pop_front();
                chk("bus_addr", {2'b0, spm_addr}, {2'b0, b.addr});
                chk("bus_rw", {31'b0, spm_rw}, {31'b0, b.rw});
                chk("bus_wdata", spm_wr_data, b.wd);
                chk("if_busy", {31'b0, if_busy}, {31'b0, b.ib});
                chk("mem_busy", {31'b0, mem_busy}, {31'b0, b.mb});
            end
        end
        if (if_rd_valid || mem_rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_valid", {30'b0, if_rd_valid, mem_rd_valid}, 32'h0);
            end else begin
                r = rd_q.pop_front();
                chk("rd_if_valid", {31'b0, if_rd_valid}, {31'b0, r.is_if});
                chk("rd_mem_valid", {31'b0, mem_rd_valid}, {31'b0, !r.is_if});
                chk("rd_if_data", if_spm_rd_data, r.is_if ? r.d : ISA_NOP);
                chk("rd_mem_data", mem_spm_rd_data, r.is_if ? 32'h0 : r.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then combinational bus still follows a request under reset.
        #3;
        chk("rst_if_valid", {31'b0, if_rd_valid}, 32'h0);
        chk("rst_mem_valid", {31'b0, mem_rd_valid}, 32'h0);
        chk("rst_if_data", if_spm_rd_data, ISA_NOP);
        chk("rst_mem_data", mem_spm_rd_data, 32'h0);
        chk("rst_starve", {29'b0, dut.starve_cnt}, 32'h0);
        chk("rst_spm_as", {31'b0, spm_as_}, 32'h1);
        drive(1'b0, 30'h5, 1'b0, 1'b1, 30'h0, READ, 32'h0, 32'h0);
        exp_bus(30'h5, READ, 32'h0, 1'b0, 1'b0);
        idle(32'hAAAA_0000);
        reset = 1'b1;
        idle(32'hBBBB_0000);
        @(negedge clk);
        chk("post_rst_if_valid", {31'b0, if_rd_valid}, 32'h0);

        // IF-only read
        drive(1'b0, 30'h1, 1'b0, 1'b1, 30'h0, READ, 32'h0, 32'h0);
        exp_bus(30'h1, READ, 32'h0, 1'b0, 1'b0);
        exp_rd(1'b1, 32'h128);
        idle(32'h128);
        @(negedge clk);
        chk("idle_spm_as", {31'b0, spm_as_}, 32'h1);
        chk("idle_spm_addr", {2'b0, spm_addr}, 32'h0);
        chk("idle_spm_rw", {31'b0, spm_rw}, 32'h1);

        // Contention: MEM wins
        drive(1'b0, 30'h10, 1'b0, 1'b0, 30'h58, READ, 32'h0, 32'h0);
        exp_bus(30'h58, READ, 32'h0, 1'b1, 1'b0);
        exp_rd(1'b0, 32'h77);
        idle(32'h77);

        // Starvation: 4 MEM grants, IF on the 5th, MEM again on the 6th, back-to-back returns
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 30'h40, 1'b0, 1'b0, 30'(32'h20 + i), READ, 32'h0,
                  (i == 0) ? 32'h0 : 32'h1000 + 32'(i) - 32'h1);
            if (i == 4) begin
                exp_bus(30'h40, READ, 32'h0, 1'b0, 1'b1);
                exp_rd(1'b1, 32'h1000 + 32'(i));
            end else begin
                exp_bus(30'(32'h20 + i), READ, 32'h0, 1'b1, 1'b0);
                exp_rd(1'b0, 32'h1000 + 32'(i));
            end
        end
        idle(32'h1005);

        // MEM write: no valid afterwards
        drive(1'b1, 30'h0, 1'b0, 1'b0, 30'h4a, WRITE, 32'hDEAD_BEEF, 32'h0);
        exp_bus(30'h4a, WRITE, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(32'h1234);
        @(negedge clk);
        chk("wr_no_if_valid", {31'b0, if_rd_valid}, 32'h0);
        chk("wr_no_mem_valid", {31'b0, mem_rd_valid}, 32'h0);
        chk("wr_mem_data", mem_spm_rd_data, 32'h0);

        // Flush cancels an IF return
        drive(1'b0, 30'h8, 1'b0, 1'b1, 30'h0, READ, 32'h0, 32'h0);
        exp_bus(30'h8, READ, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, READ, 32'h0, 32'hABCD);
        @(negedge clk);
        chk("flush_if_valid", {31'b0, if_rd_valid}, 32'h0);
        chk("flush_if_data", if_spm_rd_data, ISA_NOP);

        // Flush has no effect on a MEM return
        drive(1'b1, 30'h0, 1'b0, 1'b0, 30'h30, READ, 32'h0, 32'h0);
        exp_bus(30'h30, READ, 32'h0, 1'b0, 1'b0);
        exp_rd(1'b0, 32'h99);
        drive(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, READ, 32'h0, 32'h99);

        // Async reset mid-read after an IF grant
        drive(1'b0, 30'h3, 1'b0, 1'b1, 30'h0, READ, 32'h0, 32'h0);
        exp_bus(30'h3, READ, 32'h0, 1'b0, 1'b0);
        idle(32'h55);
        chk("pre_rst_if_valid", {31'b0, if_rd_valid}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_if_valid", {31'b0, if_rd_valid}, 32'h0);
        chk("async_rst_if_data", if_spm_rd_data, ISA_NOP);
        chk("async_rst_starve", {29'b0, dut.starve_cnt}, 32'h0);
        idle(32'h55);
        reset = 1'b1;
        idle(32'h55);
        @(negedge clk);
        chk("no_stale_if_valid", {31'b0, if_rd_valid}, 32'h0);

        // Async reset mid-read with a MEM return pending and IF starving
        drive(1'b0, 30'h3, 1'b0, 1'b0, 30'h60, READ, 32'h0, 32'h0);
        exp_bus(30'h60, READ, 32'h0, 1'b1, 1'b0);
        idle(32'h66);
        chk("pre_rst_mem_valid", {31'b0, mem_rd_valid}, 32'h1);
        chk("pre_rst_starve", {29'b0, dut.starve_cnt}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_mem_valid", {31'b0, mem_rd_valid}, 32'h0);
        chk("async_rst_mem_data", mem_spm_rd_data, 32'h0);
        chk("async_rst_starve2", {29'b0, dut.starve_cnt}, 32'h0);
        idle(32'h66);
        reset = 1'b1;
        idle(32'h66);
        @(negedge clk);
        chk("no_stale_mem_valid", {31'b0, mem_rd_valid}, 32'h0);

        idle(32'h0);
        idle(32'h0);
        @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 32'h0);
        chk("rd_q_drained", rd_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spm_arbiter.md
SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BURST_MAX, default 4, meaning the maximum consecutive MEM grants while IF waits (range 1..7).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port if_spm_addr  input  `WORD_ADDR_W (30)  IF fetch word address.
REQ-005 The block SHALL have port if_spm_as_  input  1  IF request strobe, active-low.
REQ-006 The block SHALL have port if_flush  input  1  IF pipeline flush; cancels IF read data returning this cycle.
REQ-007 The block SHALL have port if_spm_rd_data  output  `WORD_DATA_W (32)  IF read data.
REQ-008 The block SHALL have port if_rd_valid  output  1  IF read data valid.
REQ-009 The block SHALL have port if_busy  output  1  IF request denied this cycle; drives IF stall.
REQ-010 The block SHALL have port mem_spm_addr  input  30  MEM word address.
REQ-011 The block SHALL have port mem_spm_as_  input  1  MEM request strobe, active-low.
REQ-012 The block SHALL have port mem_spm_rw  input  1  MEM access type, `READ / `WRITE.
REQ-013 The block SHALL have port mem_spm_wr_data  input  32  MEM write data.
REQ-014 The block SHALL have port mem_spm_rd_data  output  32  MEM read data.
REQ-015 The block SHALL have port mem_rd_valid  output  1  MEM read data valid.
REQ-016 The block SHALL have port mem_busy  output  1  MEM request denied this cycle.
REQ-017 The block SHALL have ports spm_addr output 30, spm_as_ output 1, spm_rw output 1, spm_wr_data output 32, and spm_rd_data input 32 — the single-port SPM bus with synchronous read (data one cycle after strobe).

Function
REQ-018 The grant SHALL be combinational per cycle: MEM if mem_spm_as_=`ENABLE_, else IF if if_spm_as_=`ENABLE_, else none.
REQ-019 The grant SHALL override the MEM-first rule to IF when both request and starve_cnt == MEM_BURST_MAX.
REQ-020 starve_cnt SHALL be a 3-bit counter: +1 on each edge where MEM is granted while IF requests; cleared when IF is granted or IF is idle; it never exceeds MEM_BURST_MAX.
REQ-021 The SPM bus SHALL mirror the granted requester; for an IF grant, spm_rw=`READ and spm_wr_data=0.
REQ-022 With no grant, the SPM bus SHALL drive spm_as_=`DISABLE_, spm_addr=0, spm_rw=`READ, spm_wr_data=0.
REQ-023 if_busy SHALL equal (IF requests and not granted); mem_busy SHALL equal (MEM requests and not granted); both combinational.
REQ-024 A registered state rd_owner {IDLE, IF, MEM} SHALL capture at each edge the owner of a granted read (IDLE for a MEM write or no grant).
REQ-025 if_rd_valid SHALL be (rd_owner==IF and !if_flush).
REQ-026 mem_rd_valid SHALL be (rd_owner==MEM).
REQ-027 Read latency SHALL be exactly 1 cycle from grant to valid.
REQ-028 if_spm_rd_data SHALL be spm_rd_data when if_rd_valid, else `ISA_NOP.
REQ-029 mem_spm_rd_data SHALL be spm_rd_data when mem_rd_valid, else 0.
REQ-030 A MEM write SHALL complete in its grant cycle; no valid is produced for it.
REQ-031 On back-to-back grants, the new grant SHALL proceed in the same cycle the previous read data is returned; there is no bubble.
REQ-032 An if_flush in a cycle where rd_owner != IF SHALL have no effect.

Reset
REQ-033 While reset=0, the block SHALL hold rd_owner=IDLE, starve_cnt=0, if_rd_valid=0, mem_rd_valid=0, if_spm_rd_data=`ISA_NOP, and mem_spm_rd_data=0, taking effect immediately without waiting for a clock edge.
REQ-034 Reset asserted mid-read SHALL drop the pending valid with no stale data delivered after reset release.
REQ-035 Combinational bus outputs SHALL still follow requests during reset.

Verification
REQ-036 The bench SHALL cover IF-only read: if_spm_as_=0, addr 0x1, spm_rd_data=0x128 next cycle -> spm_addr=0x1, if_busy=0, next cycle if_rd_valid=1, if_spm_rd_data=0x128.
REQ-037 The bench SHALL cover contention: both request, MEM read addr 0x58 -> spm_addr=0x58, if_busy=1, next cycle mem_rd_valid=1, if_rd_valid=0.
REQ-038 The bench SHALL cover starvation with MEM_BURST_MAX=4 and both requesting continuously -> MEM granted 4 cycles, IF granted on cycle 5, MEM granted on cycle 6.
REQ-039 The bench SHALL cover MEM write: mem_spm_rw=`WRITE, addr 0x4a, data 0xDEADBEEF -> spm_rw=`WRITE, spm_wr_data=0xDEADBEEF, no valid next cycle.
REQ-040 The bench SHALL cover flush: IF read granted, if_flush=1 the next cycle -> if_rd_valid=0, if_spm_rd_data=`ISA_NOP.
REQ-041 The bench SHALL cover async reset: reset=0 between edges after an IF grant -> if_rd_valid=0 immediately, starve_cnt=0.
